// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: one 32-bit column per cycle, valid/ready handshake at both ends.
// Optional inverse S-box selected by macro SUB_BYTES_INV_EN.
module sub_bytes_iter (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out
`ifdef SUB_BYTES_INV_EN
   ,
   input  logic         inv
`endif
);

   localparam logic [0:255][7:0] FWD_SBOX = {
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

`ifdef SUB_BYTES_INV_EN
   localparam logic [0:255][7:0] INV_SBOX = {
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [1:0]     cnt_q, cnt_d;
   logic [127:0]   blk_q, blk_d;
   logic [127:0]   out_q, out_d;
   logic           out_valid_q, out_valid_d;
   logic [31:0]    col_in, col_sub;
   logic [127:0]   blk_upd;
`ifdef SUB_BYTES_INV_EN
   logic           inv_q, inv_d;
`endif

   always_comb begin
      col_in = blk_q[127:96];
      case (cnt_q)
         2'd0: col_in = blk_q[127:96];
         2'd1: col_in = blk_q[95:64];
         2'd2: col_in = blk_q[63:32];
         2'd3: col_in = blk_q[31:0];
         default: col_in = blk_q[127:96];
      endcase
   end

   // Four parallel byte lookups on the selected column
   always_comb begin
      col_sub = '0;
      for (int unsigned b = 0; b < 4; b++) begin
`ifdef SUB_BYTES_INV_EN
         col_sub[8*b +: 8] = inv_q ? INV_SBOX[col_in[8*b +: 8]] : FWD_SBOX[col_in[8*b +: 8]];
`else
         col_sub[8*b +: 8] = FWD_SBOX[col_in[8*b +: 8]];
`endif
      end
   end

   always_comb begin
      blk_upd = blk_q;
      case (cnt_q)
         2'd0: blk_upd[127:96] = col_sub;
         2'd1: blk_upd[95:64]  = col_sub;
         2'd2: blk_upd[63:32]  = col_sub;
         2'd3: blk_upd[31:0]   = col_sub;
         default: blk_upd = blk_q;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      blk_d       = blk_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
`ifdef SUB_BYTES_INV_EN
      inv_d       = inv_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               blk_d   = in;
               cnt_d   = 2'd0;
               state_d = BUSY;
`ifdef SUB_BYTES_INV_EN
               inv_d   = inv;
`endif
            end
         end
         BUSY: begin
            blk_d = blk_upd;
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
               out_d       = blk_upd;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         blk_q       <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
`ifdef SUB_BYTES_INV_EN
         inv_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         blk_q       <= blk_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
`ifdef SUB_BYTES_INV_EN
         inv_q       <= inv_d;
`endif
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign out       = out_q;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Directed self-checking bench for sub_bytes_iter; inputs change on negedge, outputs sampled on negedge.
module tb_sub_bytes_iter;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out;
   logic         inv;

   int n_chk  = 0;
   int n_fail = 0;

   localparam logic [127:0] VEC_IN   = 128'h193de3be_a0f4e22b_9ac68d2a_e9f84808;
   localparam logic [127:0] VEC_OUT  = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;
   localparam logic [127:0] SEQ_IN   = 128'h00010203_04050607_08090a0b_0c0d0e0f;
   localparam logic [127:0] SEQ_OUT  = 128'h637c777b_f26b6fc5_3001672b_fed7ab76;
   localparam logic [127:0] ALL_00   = {16{8'h00}};
   localparam logic [127:0] ALL_FF   = {16{8'hff}};
   localparam logic [127:0] ALL_63   = {16{8'h63}};
   localparam logic [127:0] ALL_16   = {16{8'h16}};

   always #5 clk = ~clk;

   sub_bytes_iter dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in        (in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out)
`ifdef SUB_BYTES_INV_EN
      ,
      .inv       (inv)
`endif
   );

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   logic [127:0] held;

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in        = '0;
      out_ready = 1'b0;
      inv       = 1'b0;
      @(negedge clk);
      tick();
      tick();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out", out, ALL_00);

      // reset wins over an input handshake on the same edge
      in_valid = 1'b1;
      in       = VEC_IN;
      tick();
      chk("rst_prio_in_ready", in_ready, 1);
      rst      = 1'b0;
      in_valid = 1'b0;
      tick();
      chk("idle_hold_in_ready", in_ready, 1);

      // forward vector with exact latency
      in        = VEC_IN;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      in       = '0;
      chk("fwd_busy_in_ready", in_ready, 0);
      chk("fwd_e0_valid", out_valid, 0);
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk($sformatf("fwd_e%0d_valid", i), out_valid, 0);
      end
      tick();
      chk("fwd_e4_valid", out_valid, 1);
      chk("fwd_out", out, VEC_OUT);
      chk("fwd_done_in_ready", in_ready, 0);
      tick();
      chk("fwd_e5_valid", out_valid, 0);
      chk("fwd_e5_in_ready", in_ready, 1);
      chk("fwd_out_kept", out, VEC_OUT);

      // back-to-back boundary blocks with in_valid held high
      in       = ALL_00;
      in_valid = 1'b1;
      tick();
      in = ALL_FF;
      tick(); tick(); tick();
      chk("b2b_00_not_yet", out_valid, 0);
      tick();
      chk("b2b_00_valid", out_valid, 1);
      chk("b2b_00_out", out, ALL_63);
      tick();
      chk("b2b_idle_valid", out_valid, 0);
      chk("b2b_idle_in_ready", in_ready, 1);
      tick();
      chk("b2b_ff_accepted", in_ready, 0);
      in_valid = 1'b0;
      tick(); tick(); tick(); tick();
      chk("b2b_ff_valid", out_valid, 1);
      chk("b2b_ff_out", out, ALL_16);
      tick();
      chk("b2b_ff_done", out_valid, 0);

      // backpressure in DONE
      out_ready = 1'b0;
      in        = VEC_IN;
      in_valid  = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick(); tick(); tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_out", out, VEC_OUT);
      held = out;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk($sformatf("bp_hold%0d", i), {out_valid, in_ready, out}, {1'b1, 1'b0, held});
      end
      out_ready = 1'b1;
      tick();
      chk("bp_release_valid", out_valid, 0);
      chk("bp_release_in_ready", in_ready, 1);

      // reset during the second BUSY cycle
      in       = SEQ_IN;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_valid", out_valid, 0);
      chk("abort_out", out, ALL_00);
      chk("abort_in_ready", in_ready, 1);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk($sformatf("abort_no_stale%0d", i), {out_valid, out}, {1'b0, ALL_00});
      end

      // inputs changing during BUSY are ignored
      in       = SEQ_IN;
      in_valid = 1'b1;
      tick();
      in = ALL_FF;
      tick(); tick();
      in = VEC_IN;
      tick();
      in_valid = 1'b0;
      tick();
      chk("chg_valid", out_valid, 1);
      chk("chg_out", out, SEQ_OUT);
      tick();
      chk("chg_done", out_valid, 0);

`ifdef SUB_BYTES_INV_EN
      // inverse block, inv toggled mid-operation
      inv      = 1'b1;
      in       = VEC_OUT;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      inv      = 1'b0;
      tick();
      inv = 1'b1;
      tick();
      inv = 1'b0;
      tick(); tick();
      chk("inv_valid", out_valid, 1);
      chk("inv_out", out, VEC_IN);
      tick();
      in       = VEC_IN;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      inv      = 1'b1;
      tick(); tick(); tick(); tick();
      chk("fwd_after_inv_out", out, VEC_OUT);
      tick();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
